// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the sequenced 4-input neuron.
// Holds the datapath width, the input count, the FSM state codes, the
// last MAC index and the latched operand-set record.
package neuron_mac_sequencer_pkg;
  localparam int WIDTH = 32;
  localparam int N_IN  = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_BIAS   = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;
  localparam logic [1:0] LAST_IDX = 2'd3;

  typedef logic [WIDTH-1:0] word_t;

  // One operand set; index 0 holds x1/w1.
  typedef struct packed {
    logic [N_IN-1:0][WIDTH-1:0] x;
    logic [N_IN-1:0][WIDTH-1:0] w;
    word_t                      b;
  } opset_t;
endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Operand-in / result-out handshake bundle of the neuron sequencer.
//   in_valid/in_ready : operand set handshake (x1..x4, w1..w4, b)
//   out_valid/out_ready: result handshake (f)
// slave  : the sequencer side
// master : the source/sink side
interface neuron_mac_sequencer_if;
  import neuron_mac_sequencer_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t x1, x2, x3, x4;
  word_t w1, w2, w3, w4;
  word_t b;
  logic  out_valid;
  logic  out_ready;
  word_t f;

  modport slave (
    input  in_valid, x1, x2, x3, x4, w1, w2, w3, w4, b, out_ready,
    output in_ready, out_valid, f
  );

  modport master (
    output in_valid, x1, x2, x3, x4, w1, w2, w3, w4, b, out_ready,
    input  in_ready, out_valid, f
  );
endinterface

// File: rtl/neuron_mac_sequencer_relu.sv
// relu_32b4: 32-bit signed ReLU.
//   a : signed input
//   y : a when non-negative, else 0
module relu_32b4 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = a[31] ? 32'd0 : a;
endmodule

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: f = ReLU(sum(w[i]*x[i]) + b) computed over five
// cycles with one shared multiplier and one shared adder.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   io   : operand/result handshake bundle (slave side)
//   busy : high whenever the FSM is not idle
module neuron_mac_sequencer
  import neuron_mac_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  neuron_mac_sequencer_if.slave io,
  output logic                  busy
);
  logic [1:0] state;
  logic [1:0] idx;
  word_t      acc;
  opset_t     ops;
  opset_t     ops_in;
  word_t      prod;
  word_t      addend;
  word_t      sum;
  word_t      relu_y;
  logic       accept;
  logic       out_valid;

  assign ops_in.x = {io.x4, io.x3, io.x2, io.x1};
  assign ops_in.w = {io.w4, io.w3, io.w2, io.w1};
  assign ops_in.b = io.b;

  // A new set can enter when idle, or when the current result leaves on
  // this same edge.
  assign io.in_ready = !rst && ((state == S_IDLE) ||
                                ((state == S_OUT) && io.out_ready));
  assign accept      = io.in_valid && io.in_ready;

  // Low 32 bits of the product are identical for signed and unsigned
  // operands, so no sign handling is needed.
  assign prod   = ops.x[idx] * ops.w[idx];
  assign addend = (state == S_BIAS) ? ops.b : prod;
  assign sum    = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      acc   <= '0;
      ops   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ops   <= ops_in;
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= sum;
          idx <= idx + 2'd1;
          if (idx == LAST_IDX) state <= S_BIAS;
        end
        S_BIAS: begin
          acc   <= sum;
          state <= S_OUT;
        end
        default: begin
          if (io.out_ready) begin
            if (accept) begin
              ops   <= ops_in;
              acc   <= '0;
              idx   <= '0;
              state <= S_MAC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  relu_32b4 u_relu (
    .a (acc),
    .y (relu_y)
  );

  assign out_valid    = (state == S_OUT);
  assign io.out_valid = out_valid;
  assign io.f         = out_valid ? relu_y : '0;
  assign busy         = (state != S_IDLE);
endmodule
